// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of vga_timing_gen: pattern controls in, sync/coords/colour out.
interface vga_timing_gen_if #(
    parameter int unsigned COLOR_W = 1
);
    logic [1:0]         mode;
    logic               pause;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [10:0]        x;
    logic [9:0]         y;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               frame_start;
    logic [7:0]         frame_cnt;

    modport master (
        input  mode, pause,
        output hsync, vsync, de, x, y, r, g, b, frame_start, frame_cnt
    );

    modport slave (
        output mode, pause,
        input  hsync, vsync, de, x, y, r, g, b, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and test-pattern generator; all outputs registered one clk after hcnt/vcnt.
// Optional macro VGA_BORDER_EN paints a one-pixel all-ones frame around the visible area.
module vga_timing_gen #(
    parameter int unsigned H_VIS       = 800,
    parameter int unsigned H_FP        = 56,
    parameter int unsigned H_SYNC      = 120,
    parameter int unsigned H_BP        = 64,
    parameter int unsigned V_VIS       = 600,
    parameter int unsigned V_FP        = 37,
    parameter int unsigned V_SYNC      = 6,
    parameter int unsigned V_BP        = 23,
    parameter int unsigned H_POL       = 1,
    parameter int unsigned V_POL       = 1,
    parameter int unsigned COLOR_W     = 1,
    parameter int unsigned CHECK_SHIFT = 5
) (
    input logic              clk,
    input logic              rst_n,
    vga_timing_gen_if.master bus
);
    localparam int unsigned H_PER = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_PER = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned BAR_W = H_VIS / 8;

    if (H_VIS < 8 || V_VIS < 8 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 ||
        V_SYNC < 1 || V_BP < 1 || H_PER > 2048 || V_PER > 1024 || COLOR_W < 1 ||
        CHECK_SHIFT > 7) begin : g_param_err
        $error("vga_timing_gen: illegal parameter set");
    end

    localparam logic [10:0] H_LAST    = 11'(H_PER - 1);
    localparam logic [10:0] H_VIS_L   = 11'(H_VIS);
    localparam logic [10:0] H_SS      = 11'(H_VIS + H_FP);
    localparam logic [10:0] H_SE      = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] BAR_LAST  = 11'(BAR_W - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_PER - 1);
    localparam logic [9:0]  V_VIS_L   = 10'(V_VIS);
    localparam logic [9:0]  V_SS      = 10'(V_VIS + V_FP);
    localparam logic [9:0]  V_SE      = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic        HS_ON     = 1'(H_POL);
    localparam logic        VS_ON     = 1'(V_POL);

    logic [10:0]        hcnt;
    logic [9:0]         vcnt;
    logic [7:0]         frame_cnt_q;
    logic [1:0]         mode_q;
    logic [2:0]         bar_idx;
    logic [10:0]        bar_px;
    logic               h_last, v_last, vis, chk;
    logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

    always_comb begin
        h_last = (hcnt == H_LAST);
        v_last = (vcnt == V_LAST);
        vis    = (hcnt < H_VIS_L) && (vcnt < V_VIS_L);
        // Only bit CHECK_SHIFT of each sum matters, so the low slices suffice.
        chk = 1'((hcnt[CHECK_SHIFT:0] + frame_cnt_q[CHECK_SHIFT:0]) >> CHECK_SHIFT) ^
              1'((vcnt[CHECK_SHIFT:0] + frame_cnt_q[CHECK_SHIFT:0]) >> CHECK_SHIFT);
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        case (mode_q)
            2'd1: begin
                pix_r = {COLOR_W{chk}};
                pix_g = {COLOR_W{~chk}};
            end
            2'd2: begin
                pix_r = {COLOR_W{bar_idx[2]}};
                pix_g = {COLOR_W{bar_idx[1]}};
                pix_b = {COLOR_W{bar_idx[0]}};
            end
            2'd3: begin
                pix_r = '1;
                pix_g = '1;
                pix_b = '1;
            end
            default: ;
        endcase
`ifdef VGA_BORDER_EN
        if (hcnt == 11'd0 || hcnt == H_VIS_L - 11'd1 || vcnt == 10'd0 ||
            vcnt == V_VIS_L - 10'd1) begin
            pix_r = '1;
            pix_g = '1;
            pix_b = '1;
        end
`endif
        if (!vis) begin
            pix_r = '0;
            pix_g = '0;
            pix_b = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt            <= '0;
            vcnt            <= '0;
            frame_cnt_q     <= '0;
            mode_q          <= '0;
            bar_idx         <= '0;
            bar_px          <= '0;
            bus.hsync       <= ~HS_ON;
            bus.vsync       <= ~VS_ON;
            bus.de          <= 1'b0;
            bus.x           <= '0;
            bus.y           <= '0;
            bus.r           <= '0;
            bus.g           <= '0;
            bus.b           <= '0;
            bus.frame_start <= 1'b0;
            bus.frame_cnt   <= '0;
        end else begin
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 11'd1;
            end
            if (h_last && v_last) begin
                mode_q <= bus.mode;
                if (!bus.pause) frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            // Bar index tracks hcnt/BAR_W without a divider; leftover pixels stay in bar 7.
            if (h_last) begin
                bar_idx <= '0;
                bar_px  <= '0;
            end else if (hcnt < H_VIS_L) begin
                if (bar_px == BAR_LAST) begin
                    bar_px <= '0;
                    if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_px <= bar_px + 11'd1;
                end
            end
            bus.hsync <= (hcnt >= H_SS && hcnt < H_SE) ? HS_ON : ~HS_ON;
            bus.vsync <= (vcnt >= V_SS && vcnt < V_SE) ? VS_ON : ~VS_ON;
            bus.de    <= vis;
            if (vis) begin
                bus.x <= hcnt;
                bus.y <= vcnt;
            end
            bus.r           <= pix_r;
            bus.g           <= pix_g;
            bus.b           <= pix_b;
            bus.frame_start <= (hcnt == 11'd0) && (vcnt == 10'd0);
            bus.frame_cnt   <= frame_cnt_q;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: small timing, two sync polarities, per-cycle model check.
module tb_vga_timing_gen;
    localparam int HV = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VV = 8, VFP = 1, VS = 2, VBP = 1;
    localparam int CW = 2, CS = 1;
    localparam int HPER = HV + HFP + HS + HBP;
    localparam int VPER = VV + VFP + VS + VBP;
    localparam int FRAME = HPER * VPER;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [10:0] x;
        logic [9:0]  y;
        logic [1:0]  r;
        logic [1:0]  g;
        logic [1:0]  b;
        logic        fs;
        logic [7:0]  fc;
    } outs_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] mode  = 2'd0;
    logic       pause = 1'b0;
    int vectors = 0;
    int errors  = 0;

    // Reference model: counter position being displayed, frame count, latched mode, held x/y.
    int mh = 0, mv = 0, mfc = 0, mmode = 0, mlx = 0, mly = 0;

    vga_timing_gen_if #(.COLOR_W(CW)) if_a ();
    vga_timing_gen_if #(.COLOR_W(CW)) if_b ();
    assign if_a.mode  = mode;
    assign if_a.pause = pause;
    assign if_b.mode  = mode;
    assign if_b.pause = pause;

    vga_timing_gen #(
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_POL(1), .V_POL(1), .COLOR_W(CW), .CHECK_SHIFT(CS)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if_a)
    );

    vga_timing_gen #(
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_POL(0), .V_POL(0), .COLOR_W(CW), .CHECK_SHIFT(CS)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if_b)
    );

    outs_t oa, ob;
    assign oa = {if_a.hsync, if_a.vsync, if_a.de, if_a.x, if_a.y, if_a.r, if_a.g, if_a.b,
                 if_a.frame_start, if_a.frame_cnt};
    assign ob = {if_b.hsync, if_b.vsync, if_b.de, if_b.x, if_b.y, if_b.r, if_b.g, if_b.b,
                 if_b.frame_start, if_b.frame_cnt};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string who, input outs_t act, input outs_t exp);
        check({who, ".hsync"}, 32'(act.hs), 32'(exp.hs));
        check({who, ".vsync"}, 32'(act.vs), 32'(exp.vs));
        check({who, ".de"}, 32'(act.de), 32'(exp.de));
        check({who, ".x"}, 32'(act.x), 32'(exp.x));
        check({who, ".y"}, 32'(act.y), 32'(exp.y));
        check({who, ".rgb"}, 32'({act.r, act.g, act.b}), 32'({exp.r, exp.g, exp.b}));
        check({who, ".frame_start"}, 32'(act.fs), 32'(exp.fs));
        check({who, ".frame_cnt"}, 32'(act.fc), 32'(exp.fc));
    endtask

    // Colour of pixel (h,v) straight from the pattern rules.
    function automatic logic [5:0] model_rgb(input int h, input int v, input int fc,
                                             input int md);
        logic [1:0] r, g, b;
        int off, idx;
        bit chk, vis;
        vis = (h < HV) && (v < VV);
        off = fc % (2 ** (CS + 1));
        chk = (((h + off) / (2 ** CS)) % 2) != (((v + off) / (2 ** CS)) % 2);
        idx = h / (HV / 8);
        if (idx > 7) idx = 7;
        r = 2'b00;
        g = 2'b00;
        b = 2'b00;
        case (md)
            1: begin
                r = chk ? 2'b11 : 2'b00;
                g = chk ? 2'b00 : 2'b11;
            end
            2: begin
                r = ((idx / 4) % 2 == 1) ? 2'b11 : 2'b00;
                g = ((idx / 2) % 2 == 1) ? 2'b11 : 2'b00;
                b = (idx % 2 == 1) ? 2'b11 : 2'b00;
            end
            3: begin
                r = 2'b11;
                g = 2'b11;
                b = 2'b11;
            end
            default: ;
        endcase
`ifdef VGA_BORDER_EN
        if (h == 0 || h == HV - 1 || v == 0 || v == VV - 1) begin
            r = 2'b11;
            g = 2'b11;
            b = 2'b11;
        end
`endif
        if (!vis) begin
            r = 2'b00;
            g = 2'b00;
            b = 2'b00;
        end
        return {r, g, b};
    endfunction

    // Compare process: inputs and rst_n only change just after a falling edge, so at the
    // falling edge they still hold the values seen by the preceding rising edge.
    always @(negedge clk) begin
        outs_t e;
        if (!rst_n) begin
            e = '{hs: 1'b0, vs: 1'b0, de: 1'b0, x: 11'd0, y: 10'd0, r: 2'b00, g: 2'b00,
                  b: 2'b00, fs: 1'b0, fc: 8'd0};
            cmp("rst_a", oa, e);
            e.hs = 1'b1;
            e.vs = 1'b1;
            cmp("rst_b", ob, e);
            mh = 0; mv = 0; mfc = 0; mmode = 0; mlx = 0; mly = 0;
        end else begin
            e.de = (mh < HV) && (mv < VV);
            if (e.de) begin
                mlx = mh;
                mly = mv;
            end
            e.hs = (mh >= HV + HFP) && (mh < HV + HFP + HS);
            e.vs = (mv >= VV + VFP) && (mv < VV + VFP + VS);
            e.x  = 11'(mlx);
            e.y  = 10'(mly);
            {e.r, e.g, e.b} = model_rgb(mh, mv, mfc, mmode);
            e.fs = (mh == 0) && (mv == 0);
            e.fc = 8'(mfc);
            cmp("a", oa, e);
            e.hs = ~e.hs;
            e.vs = ~e.vs;
            cmp("b", ob, e);
            if (mh == HPER - 1 && mv == VPER - 1) begin
                mmode = int'(mode);
                if (!pause) mfc = (mfc + 1) % 256;
            end
            mh = mh + 1;
            if (mh == HPER) begin
                mh = 0;
                mv = (mv + 1) % VPER;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_fs(input string name);
        int n;
        n = 0;
        tick(1);
        while (!if_a.frame_start && n < 2 * FRAME) begin
            tick(1);
            n++;
        end
        check(name, 32'(if_a.frame_start), 32'd1);
    endtask

    initial begin
        int hs_n, vs_n, de_n, fs_n, n;
        logic [2:0] bar_tab [16];
        bar_tab = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3,
                    3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
        #1 rst_n = 1'b0;
        tick(3);
        check("rst_a_hsync", 32'(if_a.hsync), 32'd0);
        check("rst_b_hsync", 32'(if_b.hsync), 32'd1);
        check("rst_b_vsync", 32'(if_b.vsync), 32'd1);
        rst_n = 1'b1;
        tick(1);
        check("first_fs", 32'(if_a.frame_start), 32'd1);
        check("first_de", 32'(if_a.de), 32'd1);

        // One full black frame: count sync, de and frame_start cycles.
        hs_n = 0; vs_n = 0; de_n = 0; fs_n = 0;
        for (int i = 0; i < FRAME; i++) begin
            hs_n += int'(if_a.hsync);
            vs_n += int'(if_a.vsync);
            de_n += int'(if_a.de);
            fs_n += int'(if_a.frame_start);
            if (i == 100) begin
                mode  = 2'd1;
                pause = 1'b1;
            end
            tick(1);
        end
        check("hsync_cycles", 32'(hs_n), 32'd36);
        check("vsync_cycles", 32'(vs_n), 32'd48);
        check("de_cycles", 32'(de_n), 32'd128);
        check("fs_per_frame", 32'(fs_n), 32'd1);
        check("fs_period", 32'(if_a.frame_start), 32'd1);

`ifndef VGA_BORDER_EN
        check("chk00_fc", 32'(if_a.frame_cnt), 32'd0);
        check("chk00_r", 32'(if_a.r), 32'd0);
        check("chk00_g", 32'(if_a.g), 32'd3);
        tick(2);
        check("chk20_x", 32'(if_a.x), 32'd2);
        check("chk20_r", 32'(if_a.r), 32'd3);
`endif
        tick(3 * FRAME);
        check("pause_fc", 32'(if_a.frame_cnt), 32'd0);
        pause = 1'b0;
        wait_fs("wait_fs_unpause");
        check("unpause_fc", 32'(if_a.frame_cnt), 32'd1);
        tick(1);
`ifndef VGA_BORDER_EN
        check("chk10_r", 32'(if_a.r), 32'd3);
`endif

        // Mode change mid-frame must wait for the next frame.
        tick(100);
        mode = 2'd3;
        wait_fs("wait_fs_white");
        check("white_rgb", 32'({if_a.r, if_a.g, if_a.b}), 32'h3f);

        mode = 2'd2;
        wait_fs("wait_fs_bars");
`ifndef VGA_BORDER_EN
        for (int i = 0; i < HV; i++) begin
            check("bar_rgb", 32'({if_a.r, if_a.g, if_a.b}),
                  32'({{2{bar_tab[i][2]}}, {2{bar_tab[i][1]}}, {2{bar_tab[i][0]}}}));
            tick(1);
        end
`endif

        for (int k = 0; k < 20; k++) begin
            mode  = 2'($urandom_range(0, 3));
            pause = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            tick($urandom_range(1, 400));
        end

        // Asynchronous reset mid-line.
        pause = 1'b0;
        mode  = 2'd1;
        tick(3 * FRAME);
        n = 0;
        while (!(if_a.de && if_a.x == 11'd9 && if_a.y == 10'd5) && n < 2 * FRAME) begin
            tick(1);
            n++;
        end
        check("wait_9_5", 32'(if_a.x), 32'd9);
        check("pre_rst_fc_nonzero", 32'(if_a.frame_cnt != 8'd0), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_de", 32'(if_a.de), 32'd0);
        check("async_x", 32'(if_a.x), 32'd0);
        check("async_y", 32'(if_a.y), 32'd0);
        check("async_fc", 32'(if_a.frame_cnt), 32'd0);
        check("async_b_hsync", 32'(if_b.hsync), 32'd1);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("rel_fs", 32'(if_a.frame_start), 32'd1);
        check("rel_xy", 32'({if_a.x, if_a.y}), 32'd0);
        check("rel_fc", 32'(if_a.frame_cnt), 32'd0);
        tick(FRAME + 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
